mono_mode_ctrl: RTL and testbench

//  Sequences the 2-bit monochrome_switcher that selects the VGA output colour path
//  (00 colour, 01 green, 10 amber, 11 grey).

---
 rtl/mono_mode_ctrl.sv | 173 +++++++++++++++++
 tb/tb_mono_mode_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mono_mode_ctrl.sv
// mono_mode_ctrl: debounced front-panel button and CPU write feed a frame-synchronous monochrome mode select.
// Optional feature macro MONO_AUTOREPEAT_EN: a held button steps the mode every REPEAT_FRAMES frames.
module mono_mode_ctrl #(
  parameter int         DEBOUNCE_CYCLES = 285714,
  parameter int         CNT_W           = 19,
  parameter bit         VSYNC_POL       = 1'b0,
  parameter logic [1:0] RESET_MODE      = 2'b00,
  parameter int         REPEAT_FRAMES   = 30
) (
  input  logic       clk_vga,
  input  logic       rst_n,
  input  logic       btn_n,
  input  logic       vsync,
  input  logic       io_we,
  input  logic [1:0] io_wdata,
  output logic [1:0] mode_pending,
  output logic [1:0] monochrome_switcher,
  output logic       update_pending,
  output logic       frame_tick
);

  typedef enum logic [2:0] {
    LOCKOUT,
    RELEASED,
    PRESS_WAIT,
    HELD,
    REL_WAIT
  } db_state_t;

  localparam logic             VS_IDLE  = ~VSYNC_POL;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Reject configurations the debounce counter or repeat counter cannot represent.
  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > (longint'(1) << CNT_W) || REPEAT_FRAMES < 1) begin : g_bad_cfg
    $error("mono_mode_ctrl: DEBOUNCE_CYCLES must be 2..2**CNT_W and REPEAT_FRAMES >= 1");
  end

  logic             btn_s1;
  logic             btn_s2;
  logic             vs_d1;
  logic             vs_d2;
  db_state_t        state;
  logic [CNT_W-1:0] db_cnt;
  logic             press_evt;
  logic [1:0]       pend_nxt;
  logic [1:0]       sw_nxt;

`ifdef MONO_AUTOREPEAT_EN
  localparam int             RPT_W    = (REPEAT_FRAMES > 1) ? $clog2(REPEAT_FRAMES) : 1;
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_FRAMES - 1);
  logic [RPT_W-1:0] rep_cnt;
`endif

  // Reset values mean "button released" and "vsync idle", so reset itself never looks like an edge.
  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      btn_s1     <= 1'b1;
      btn_s2     <= 1'b1;
      vs_d1      <= VS_IDLE;
      vs_d2      <= VS_IDLE;
      frame_tick <= 1'b0;
    end else begin
      btn_s1     <= btn_n;
      btn_s2     <= btn_s1;
      vs_d1      <= vsync;
      vs_d2      <= vs_d1;
      frame_tick <= (vs_d1 == VSYNC_POL) && (vs_d2 != VSYNC_POL);
    end
  end

  // The sample that moves RELEASED->PRESS_WAIT or HELD->REL_WAIT is already the first stable one.
  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      state     <= LOCKOUT;
      db_cnt    <= '0;
      press_evt <= 1'b0;
`ifdef MONO_AUTOREPEAT_EN
      rep_cnt   <= '0;
`endif
    end else begin
      press_evt <= 1'b0;
`ifdef MONO_AUTOREPEAT_EN
      if (state != HELD) rep_cnt <= '0;
`endif
      case (state)
        LOCKOUT: begin
          if (!btn_s2) begin
            db_cnt <= '0;
          end else if (db_cnt == CNT_LAST) begin
            state  <= RELEASED;
            db_cnt <= '0;
          end else begin
            db_cnt <= db_cnt + CNT_ONE;
          end
        end
        RELEASED: begin
          if (!btn_s2) begin
            state  <= PRESS_WAIT;
            db_cnt <= CNT_ONE;
          end
        end
        PRESS_WAIT: begin
          if (btn_s2) begin
            state  <= RELEASED;
            db_cnt <= '0;
          end else if (db_cnt == CNT_LAST) begin
            state     <= HELD;
            db_cnt    <= '0;
            press_evt <= 1'b1;
          end else begin
            db_cnt <= db_cnt + CNT_ONE;
          end
        end
        HELD: begin
          if (btn_s2) begin
            state  <= REL_WAIT;
            db_cnt <= CNT_ONE;
`ifdef MONO_AUTOREPEAT_EN
            rep_cnt <= '0;
          end else if (frame_tick) begin
            if (rep_cnt == RPT_LAST) begin
              press_evt <= 1'b1;
              rep_cnt   <= '0;
            end else begin
              rep_cnt <= rep_cnt + RPT_W'(1);
            end
`endif
          end
        end
        REL_WAIT: begin
          if (!btn_s2) begin
            state  <= HELD;
            db_cnt <= '0;
          end else if (db_cnt == CNT_LAST) begin
            state  <= RELEASED;
            db_cnt <= '0;
          end else begin
            db_cnt <= db_cnt + CNT_ONE;
          end
        end
        default: begin
          state  <= LOCKOUT;
          db_cnt <= '0;
        end
      endcase
    end
  end

  // A CPU write overrides a coincident press; the commit always takes the pre-write pending value.
  always_comb begin
    pend_nxt = mode_pending;
    if (io_we) begin
      pend_nxt = io_wdata;
    end else if (press_evt) begin
      pend_nxt = mode_pending + 2'd1;
    end
    sw_nxt = frame_tick ? mode_pending : monochrome_switcher;
  end

  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      mode_pending        <= RESET_MODE;
      monochrome_switcher <= RESET_MODE;
      update_pending      <= 1'b0;
    end else begin
      mode_pending        <= pend_nxt;
      monochrome_switcher <= sw_nxt;
      update_pending      <= (pend_nxt != sw_nxt);
    end
  end

endmodule

// File: tb/tb_mono_mode_ctrl.sv
// tb_mono_mode_ctrl: directed spec scenarios plus randomized traffic against a run-length reference model.
// Honours MONO_AUTOREPEAT_EN when defined for both DUT and bench.
module tb_mono_mode_ctrl;

  localparam int D = 16;
  localparam int R = 3;

  logic       clk_vga = 1'b0;
  logic       rst_n;
  logic       btn_n;
  logic       vsync;
  logic       io_we;
  logic [1:0] io_wdata;
  logic [1:0] mode_pending;
  logic [1:0] monochrome_switcher;
  logic       update_pending;
  logic       frame_tick;

  int total_cnt = 0;
  int pass_cnt  = 0;
  int fail_cnt  = 0;

  // Reference model: a 2-sample delay line for the button, last two vsync samples, and a debounced level.
  bit         btn_pipe[$];
  logic       v1, v2;
  logic [1:0] m_pend, m_sw;
  logic       m_upd, m_tick, m_press;
  logic       db, armed, last_s;
  int         run, rep;

  mono_mode_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W(19),
    .VSYNC_POL(1'b0),
    .RESET_MODE(2'b00),
    .REPEAT_FRAMES(R)
  ) dut (
    .clk_vga(clk_vga),
    .rst_n(rst_n),
    .btn_n(btn_n),
    .vsync(vsync),
    .io_we(io_we),
    .io_wdata(io_wdata),
    .mode_pending(mode_pending),
    .monochrome_switcher(monochrome_switcher),
    .update_pending(update_pending),
    .frame_tick(frame_tick)
  );

  always #5 clk_vga = ~clk_vga;

  task automatic check_output(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    btn_pipe = {1'b1, 1'b1};
    v1 = 1'b1; v2 = 1'b1;
    m_pend = 2'b00; m_sw = 2'b00;
    m_upd = 1'b0; m_tick = 1'b0; m_press = 1'b0;
    db = 1'b0; armed = 1'b0; last_s = 1'b1;
    run = 0; rep = 0;
  endtask

  // A level becomes the debounced level once D consecutive samples agree; a new low level is a press.
  task automatic model_edge();
    bit         s, held_before, new_press;
    logic [1:0] new_pend, new_sw;
    s = btn_pipe.pop_front();
    btn_pipe.push_back(btn_n);
    new_sw = m_tick ? m_pend : m_sw;
    if (io_we) new_pend = io_wdata;
    else if (m_press) new_pend = m_pend + 2'd1;
    else new_pend = m_pend;
    new_press   = 1'b0;
    held_before = (db == 1'b0) && armed && (last_s == 1'b0);
    run = (s == last_s) ? run + 1 : 1;
    if (s != db && run == D) begin
      db = s;
      if (s) armed = 1'b1;
      else new_press = 1'b1;
    end
`ifdef MONO_AUTOREPEAT_EN
    if (held_before && !s) begin
      if (m_tick) begin
        rep++;
        if (rep == R) begin
          new_press = 1'b1;
          rep = 0;
        end
      end
    end else begin
      rep = 0;
    end
`else
    if (held_before) rep = 0;
`endif
    m_press = new_press;
    m_upd   = (new_pend != new_sw);
    m_pend  = new_pend;
    m_sw    = new_sw;
    m_tick  = (v1 == 1'b0) && (v2 == 1'b1);
    v2 = v1;
    v1 = vsync;
    last_s = s;
  endtask

  task automatic compare_all();
    check_output("mode_pending", mode_pending, m_pend);
    check_output("switcher", monochrome_switcher, m_sw);
    check_output("update_pending", {1'b0, update_pending}, {1'b0, m_upd});
    check_output("frame_tick", {1'b0, frame_tick}, {1'b0, m_tick});
  endtask

  task automatic apply_stimulus(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_vga);
      model_edge();
      #1;
      compare_all();
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    model_reset();
    compare_all();
    repeat (2) @(posedge clk_vga);
    #1;
    compare_all();
    rst_n = 1'b1;
  endtask

  logic [1:0] press_seq[4];
  logic [1:0] exp_hold;
  int         btn_hold, vs_cnt, vs_period;

  initial begin
    rst_n = 1'b1; btn_n = 1'b1; vsync = 1'b1; io_we = 1'b0; io_wdata = 2'b00;
    #3;
    $display("[TB] reset with button released");
    do_reset();
    check_output("t1_pend", mode_pending, 2'b00);
    check_output("t1_sw", monochrome_switcher, 2'b00);
    check_output("t1_upd", {1'b0, update_pending}, 2'b00);
    apply_stimulus(20);

    $display("[TB] clean press and frame commit");
    btn_n = 1'b0;
    apply_stimulus(18);
    check_output("t2_pend_c18", mode_pending, 2'b00);
    apply_stimulus(1);
    check_output("t2_pend_c19", mode_pending, 2'b01);
    check_output("t2_upd_c19", {1'b0, update_pending}, 2'b01);
    apply_stimulus(1);
    btn_n = 1'b1;
    apply_stimulus(20);
    vsync = 1'b0;
    apply_stimulus(2);
    check_output("t2_tick", {1'b0, frame_tick}, 2'b01);
    check_output("t2_sw_before", monochrome_switcher, 2'b00);
    apply_stimulus(1);
    check_output("t2_sw", monochrome_switcher, 2'b01);
    check_output("t2_upd_clr", {1'b0, update_pending}, 2'b00);
    vsync = 1'b1;
    apply_stimulus(10);

    $display("[TB] bouncing short pulses");
    for (int i = 0; i < 3; i++) begin
      btn_n = 1'b0; apply_stimulus(10);
      btn_n = 1'b1; apply_stimulus(3);
    end
    apply_stimulus(20);
    check_output("t3_pend", mode_pending, 2'b01);

    $display("[TB] reset discards uncommitted mode");
    io_we = 1'b1; io_wdata = 2'b11;
    apply_stimulus(1);
    io_we = 1'b0;
    check_output("tr_pend", mode_pending, 2'b11);
    do_reset();
    check_output("tr_pend_rst", mode_pending, 2'b00);
    check_output("tr_sw_rst", monochrome_switcher, 2'b00);
    apply_stimulus(20);

    $display("[TB] four presses in one frame");
    press_seq = '{2'b01, 2'b10, 2'b11, 2'b00};
    for (int i = 0; i < 4; i++) begin
      btn_n = 1'b0; apply_stimulus(20);
      check_output($sformatf("t4_pend%0d", i), mode_pending, press_seq[i]);
      btn_n = 1'b1; apply_stimulus(20);
    end
    vsync = 1'b0; apply_stimulus(3);
    vsync = 1'b1;
    check_output("t4_sw", monochrome_switcher, 2'b00);
    check_output("t4_upd", {1'b0, update_pending}, 2'b00);
    apply_stimulus(10);

    $display("[TB] write collides with press and with frame_tick");
    btn_n = 1'b0;
    apply_stimulus(18);
    io_we = 1'b1; io_wdata = 2'b10;
    apply_stimulus(1);
    io_we = 1'b0;
    check_output("t5_pend_win", mode_pending, 2'b10);
    btn_n = 1'b1;
    apply_stimulus(20);
    vsync = 1'b0;
    apply_stimulus(2);
    io_we = 1'b1; io_wdata = 2'b11;
    apply_stimulus(1);
    io_we = 1'b0;
    check_output("t5_sw", monochrome_switcher, 2'b10);
    check_output("t5_pend", mode_pending, 2'b11);
    check_output("t5_upd", {1'b0, update_pending}, 2'b01);
    vsync = 1'b1; apply_stimulus(10);
    vsync = 1'b0; apply_stimulus(3);
    vsync = 1'b1; apply_stimulus(5);
    check_output("t5_sw_next", monochrome_switcher, 2'b11);

    $display("[TB] button held through reset");
    btn_n = 1'b0;
    do_reset();
    apply_stimulus(40);
    check_output("t6_pend_held", mode_pending, 2'b00);
    btn_n = 1'b1; apply_stimulus(20);
    check_output("t6_pend_rel", mode_pending, 2'b00);
    btn_n = 1'b0; apply_stimulus(19);
    check_output("t6_pend_press", mode_pending, 2'b01);
    for (int f = 0; f < 7; f++) begin
      vsync = 1'b0; apply_stimulus(3);
      vsync = 1'b1; apply_stimulus(17);
    end
`ifdef MONO_AUTOREPEAT_EN
    exp_hold = 2'b11;
`else
    exp_hold = 2'b01;
`endif
    check_output("t6_pend_7frames", mode_pending, exp_hold);
    btn_n = 1'b1; apply_stimulus(20);

    $display("[TB] randomized traffic");
    btn_hold = 10; vs_cnt = 0; vs_period = 40;
    for (int c = 0; c < 3000; c++) begin
      if (btn_hold == 0) begin
        btn_n = ~btn_n;
        case ($urandom_range(0, 3))
          0:       btn_hold = $urandom_range(1, 8);
          1:       btn_hold = $urandom_range(80, 200);
          default: btn_hold = $urandom_range(10, 40);
        endcase
      end
      btn_hold--;
      vsync = (vs_cnt < 3) ? 1'b0 : 1'b1;
      vs_cnt++;
      if (vs_cnt == vs_period) begin
        vs_cnt = 0;
        vs_period = $urandom_range(20, 80);
      end
      io_we = ($urandom_range(0, 39) == 0);
      io_wdata = 2'($urandom_range(0, 3));
      if (c == 1500) do_reset();
      apply_stimulus(1);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
